// File: rtl/mod_exp_pkg.sv
// Shared types and defaults for the modular-exponentiation sequencer.
// Build option: MODEXP_SKIP_LZ_EN enables the leading-zero exponent scan.
package mod_exp_pkg;

  localparam int unsigned W_DEF        = 1024;
  localparam int unsigned EXP_W_DEF    = 1024;
  localparam int unsigned MP_COUNT_DEF = 1023;

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_SQ,
    S_MUL,
    S_CONV,
    S_DONE
  } state_e;

  // Sub-phases of every product issued to mon_prod.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_ARM,
    PH_WAIT
  } phase_e;

endpackage

// File: rtl/exp_bit_scanner.sv
// Holds the captured exponent and the MSB-first bit index.
// Build option: MODEXP_SKIP_LZ_EN adds the one-bit-per-cycle leading-zero scan.
module exp_bit_scanner
  import mod_exp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             step,
`ifdef MODEXP_SKIP_LZ_EN
  input  logic             scan,
`endif
  output logic             cur_bit,
  output logic             last_bit
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dec;

  assign cur_bit  = exp_q[idx_q];
  assign last_bit = (idx_q == '0);

  always_comb begin
    exp_d = exp_q;
    idx_d = idx_q;
`ifdef MODEXP_SKIP_LZ_EN
    // Leading zeros are skipped by walking idx down without issuing products.
    dec = step | (scan & ~cur_bit & ~last_bit);
`else
    dec = step;
`endif
    if (load) begin
      exp_d = exp_in;
      idx_d = IDX_W'(EXP_W - 1);
    end else if (dec && !last_bit) begin
      idx_d = idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q <= '0;
      idx_q <= '0;
    end else begin
      exp_q <= exp_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one mon_prod instance.
// Build option: MODEXP_SKIP_LZ_EN skips products for leading exponent zeros.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned EXP_W    = EXP_W_DEF,
  parameter int unsigned MP_COUNT = MP_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     base_m,
  input  logic [W-1:0]     one_m,
  input  logic [EXP_W-1:0] exp,
  input  logic [W-1:0]     M,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result,
  output logic             mp_start,
  output logic [W-1:0]     mp_a,
  output logic [W-1:0]     mp_b,
  output logic [W-1:0]     mp_m,
  output logic [9:0]       mp_count,
  input  logic             mp_stop,
  input  logic [W:0]       mp_p
);

  state_e       state_q, state_d;
  phase_e       phase_q, phase_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] base_q, base_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] result_q, result_d;
  logic         load, step, cur_bit, last_bit;
  logic         prod_state;
  logic         p_msb_unused;
`ifdef MODEXP_SKIP_LZ_EN
  logic         scan;
`endif

  exp_bit_scanner #(.EXP_W(EXP_W)) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .exp_in  (exp),
    .step    (step),
`ifdef MODEXP_SKIP_LZ_EN
    .scan    (scan),
`endif
    .cur_bit (cur_bit),
    .last_bit(last_bit)
  );

  assign prod_state   = (state_q == S_SQ) || (state_q == S_MUL) || (state_q == S_CONV);
  assign p_msb_unused = mp_p[W];

  // acc only changes when a product is read, so it doubles as the stable A operand.
  assign mp_a     = acc_q;
  assign mp_b     = (state_q == S_MUL)  ? base_q :
                    (state_q == S_CONV) ? W'(1)  : acc_q;
  assign mp_m     = m_q;
  assign mp_count = 10'(MP_COUNT);
  assign mp_start = prod_state && (phase_q == PH_ISSUE);
  assign busy     = (state_q != S_DRAIN) && (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    base_d   = base_q;
    m_d      = m_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
`ifdef MODEXP_SKIP_LZ_EN
    scan     = 1'b0;
`endif
    case (state_q)
      S_DRAIN: if (mp_stop) state_d = S_IDLE;
      S_IDLE: begin
        if (start) begin
          base_d  = base_m;
          m_d     = M;
          acc_d   = one_m;
          load    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        phase_d = PH_ISSUE;
`ifdef MODEXP_SKIP_LZ_EN
        state_d = S_SCAN;
`else
        state_d = S_SQ;
`endif
      end
      S_SCAN: begin
`ifdef MODEXP_SKIP_LZ_EN
        scan = 1'b1;
        // The first set bit seeds acc with the base, standing in for its SQ/MUL pair.
        if (cur_bit) begin
          acc_d = base_q;
          if (last_bit) state_d = S_CONV;
          else begin
            step    = 1'b1;
            state_d = S_SQ;
          end
        end else if (last_bit) begin
          state_d = S_CONV;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_SQ, S_MUL, S_CONV: begin
        case (phase_q)
          PH_ISSUE: phase_d = PH_ARM;
          PH_ARM:   phase_d = PH_WAIT;
          PH_WAIT: begin
            if (mp_stop) begin
              phase_d = PH_ISSUE;
              if (state_q == S_CONV) begin
                result_d = mp_p[W-1:0];
                state_d  = S_DONE;
              end else begin
                acc_d = mp_p[W-1:0];
                if ((state_q == S_SQ) && cur_bit) state_d = S_MUL;
                else if (last_bit) state_d = S_CONV;
                else begin
                  step    = 1'b1;
                  state_d = S_SQ;
                end
              end
            end
          end
          default: phase_d = PH_ISSUE;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_DRAIN;
      phase_q  <= PH_ISSUE;
      acc_q    <= '0;
      base_q   <= '0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural Montgomery mon_prod model.
// Honours MODEXP_SKIP_LZ_EN when computing expected product counts.
module tb_mod_exp_ctrl;

  localparam int unsigned W        = 64;
  localparam int unsigned EXP_W    = 16;
  localparam int unsigned MP_COUNT = 63;
  localparam int unsigned W2       = 2 * W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     base_m = '0, one_m = '0, m_in = '0;
  logic [EXP_W-1:0] exp_in = '0;
  logic             busy, done, mp_start;
  logic [W-1:0]     result, mp_a, mp_b, mp_m;
  logic [9:0]       mp_count;
  logic             mp_stop = 1'b0;
  logic [W:0]       mp_p = '0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.W(W), .EXP_W(EXP_W), .MP_COUNT(MP_COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_m(base_m), .one_m(one_m),
    .exp(exp_in), .M(m_in), .busy(busy), .done(done), .result(result),
    .mp_start(mp_start), .mp_a(mp_a), .mp_b(mp_b), .mp_m(mp_m),
    .mp_count(mp_count), .mp_stop(mp_stop), .mp_p(mp_p)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, m);
    logic [W2-1:0] t;
    t = W2'(a) * W2'(b);
    return W'(t % W2'(m));
  endfunction

  function automatic logic [W-1:0] powmod(input logic [W-1:0] b, input logic [EXP_W-1:0] e,
                                          input logic [W-1:0] m);
    logic [W-1:0] r, bb;
    r  = W'(1) % m;
    bb = b % m;
    for (int i = 0; i < int'(EXP_W); i++) begin
      if (e[i]) r = mulmod(r, bb, m);
      bb = mulmod(bb, bb, m);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, m);
    logic [W2-1:0] t;
    t = {x % m, W'(0)};
    return W'(t % W2'(m));
  endfunction

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, m);
    logic [W+1:0] p;
    p = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (a[i]) p = p + {2'b00, b};
      if (p[0]) p = p + {2'b00, m};
      p = p >> 1;
    end
    if (p >= {2'b00, m}) p = p - {2'b00, m};
    return p[W-1:0];
  endfunction

  function automatic int unsigned nprod_of(input logic [EXP_W-1:0] e);
    int unsigned pop;
    pop = $countones(e);
`ifdef MODEXP_SKIP_LZ_EN
    if (e == '0) return 1;
    for (int i = int'(EXP_W) - 1; i >= 0; i--)
      if (e[i]) return int'(i) + pop;
    return 1;
`else
    return EXP_W + pop + 1;
`endif
  endfunction

  function automatic logic [W-1:0] rand_mod();
    logic [W-1:0] m;
    m = {$urandom, $urandom};
    m[W-1] = 1'b1;
    m[0]   = 1'b1;
    return m;
  endfunction

  // ---------------- mon_prod model ----------------
  bit           mp_busy = 1'b1;
  int unsigned  mp_cnt = 4;
  logic [W-1:0] cap_a = '0, cap_b = '0, cap_m = '0;
  bit           disturbed = 1'b1;
  bit           stable_ok = 1'b1;
  bit           use_fixed = 1'b0;
  int unsigned  fixed_lat = 0;

  always @(posedge clk) if (!rst_n && mp_busy) disturbed = 1'b1;

  always @(negedge clk) begin
    if (mp_busy) begin
      if (mp_a !== cap_a || mp_b !== cap_b || mp_m !== cap_m) stable_ok = 1'b0;
      if (mp_cnt == 0) begin
        mp_p    <= {1'($urandom_range(0, 1)), mont(cap_a, cap_b, cap_m)};
        mp_stop <= 1'b1;
        mp_busy = 1'b0;
        if (!disturbed) chk("operand_stable", W'(stable_ok), W'(1));
      end else begin
        mp_cnt--;
      end
    end else if (mp_start) begin
      cap_a     = mp_a;
      cap_b     = mp_b;
      cap_m     = mp_m;
      mp_busy   = 1'b1;
      stable_ok = 1'b1;
      disturbed = !rst_n;
      mp_cnt    = use_fixed ? fixed_lat : $urandom_range(0, 3);
      mp_stop  <= 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [W-1:0] res;
    int unsigned  nprod;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned prod_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prod_cnt = 0;
    end else begin
      if (mp_start) prod_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=%h required=none", result);
        end else begin
          mon_e = sb_q.pop_front();
          chk("result", result, mon_e.res);
          chk("prod_count", W'(prod_cnt), W'(mon_e.nprod));
        end
        prod_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((!mp_stop || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("idle_wait");
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [W-1:0] b, m, input logic [EXP_W-1:0] e);
    base_m = to_mont(b, m);
    one_m  = to_mont(W'(1), m);
    m_in   = m;
    exp_in = e;
  endtask

  task automatic run_op(input logic [W-1:0] b, m, input logic [EXP_W-1:0] e,
                        input logic [W-1:0] want, input bit hammer);
    int n;
    exp_t ent;
    wait_idle();
    drive_op(b, m, e);
    ent.res   = want;
    ent.nprod = nprod_of(e);
    sb_q.push_back(ent);
    start = 1'b1;
    @(negedge clk);
    start = hammer;
    chk("busy_after_start", W'(busy), W'(1));
    n = 0;
    while (!done && n < 5000) begin
      if (hammer) drive_op({$urandom, $urandom}, rand_mod(), EXP_W'($urandom));
      @(negedge clk);
      n++;
    end
    if (!done) begin
      fail_now("done_wait");
      start = 1'b0;
      return;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", W'(busy), W'(0));
    chk("result_hold", result, want);
    if (hammer) begin
      @(negedge clk);
      chk("start_in_done_ignored", W'(busy), W'(0));
    end
  endtask

  task automatic reset_mid_mul();
    int n, k;
    exp_t ent;
    wait_idle();
    use_fixed = 1'b1;
    fixed_lat = 6;
    drive_op(W'(3), W'(1019), '1);
    ent.res   = powmod(W'(3), '1, W'(1019));
    ent.nprod = nprod_of('1);
    sb_q.push_back(ent);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    k = 0;
    // With an all-ones exponent the 4th product is a multiply.
    while (k < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (mp_start) k++;
    end
    if (k < 4) fail_now("mul_wait");
    repeat (2) @(negedge clk);
    sb_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_mp_start", W'(mp_start), W'(0));
    chk("rst_mp_a", mp_a, '0);
    chk("rst_result", result, '0);
    use_fixed = 1'b0;
  endtask

  initial begin
    logic [W-1:0] b, m;
    logic [EXP_W-1:0] e;
    repeat (2) begin
      @(negedge clk);
      chk("por_busy", W'(busy), W'(0));
      chk("por_done", W'(done), W'(0));
      chk("por_mp_start", W'(mp_start), W'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("drain_busy", W'(busy), W'(0));
    chk("mp_count", W'(mp_count), W'(MP_COUNT));

    run_op(W'(2), W'(1019), EXP_W'(10), W'(5), 1'b0);
    run_op(W'(5), W'(1019), EXP_W'(0), W'(1), 1'b0);
    run_op(W'(1500), W'(1019), EXP_W'(1), W'(481), 1'b0);
    e = EXP_W'($urandom);
    run_op(W'(7), W'(1019), e, powmod(W'(7), e, W'(1019)), 1'b1);
    reset_mid_mul();
    run_op(W'(2), W'(1019), EXP_W'(10), W'(5), 1'b0);

    for (int i = 0; i < 100; i++) begin
      m = rand_mod();
      b = {$urandom, $urandom};
      e = EXP_W'($urandom);
      run_op(b, m, e, powmod(b, e, m), 1'b0);
    end

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) fail_now("scoreboard_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
